// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Iterative shift-add multiplier for the EX stage. It handles mul, mulh and
// mulhu (aluop 0101/0110/0111). The pipeline is stalled through `busy` while
// the multiplier runs one iteration per cycle for WIDTH cycles. The selected
// product word is handed over as a registered result, together with a
// one-cycle `done` pulse.
//
// Ports
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      level: EX-stage instruction is an M-extension R-type op
//   aluop   in   4      0101 mul (low), 0110 mulh (signed high), 0111 mulhu
//   a       in   WIDTH  rs1 operand (forwarded)
//   b       in   WIDTH  rs2 operand (forwarded)
//   busy    out  1      stall request: accepting cycle plus every RUN cycle
//   done    out  1      one-cycle pulse; result is valid, pipeline advances
//   result  out  WIDTH  selected product word, held until the next completion
//
// Timing: start is seen in cycle N, and done/result appear in cycle
// N+WIDTH+1. The latency does not depend on the operand values.
// -----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P = PW'(1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHU
    } op_t;

    state_t           state_q,  state_d;
    op_t              op_q,     op_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             sign_q,   sign_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Decode of the incoming operation.
    logic             valid_op;
    op_t              op_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Datapath values for the current iteration.
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    prod;
    logic             busy_c;

    always_comb begin
        valid_op = 1'b1;
        op_in    = OP_MUL;
        unique case (aluop)
            4'b0101: op_in = OP_MUL;
            4'b0110: op_in = OP_MULH;
            4'b0111: op_in = OP_MULHU;
            default: valid_op = 1'b0;
        endcase
    end

    // The magnitude of -2^(W-1) wraps to 2^(W-1). That value is still
    // correct when it is read as a W-bit unsigned number.
    assign abs_a = a[WIDTH-1] ? (~a + ONE_W) : a;
    assign abs_b = b[WIDTH-1] ? (~b + ONE_W) : b;

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod    = sign_q ? (~acc_sum + ONE_P) : acc_sum;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_c   = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && valid_op) begin
                    busy_c = 1'b1;
                    op_d   = op_in;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (op_in == OP_MULH) begin
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        mplier_d = abs_b;
                        sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        sign_d   = 1'b0;
                    end
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy_c   = 1'b1;
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[PW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                // The product is resolved on the final iteration edge.
                // This keeps result registered and already valid during the
                // DONE cycle.
                if (cnt_q == LAST) begin
                    result_d = (op_q == OP_MUL) ? prod[WIDTH-1:0]
                                                : prod[PW-1:WIDTH];
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Gating with rst drops the stall as soon as reset asserts, even if the
    // stalled instruction is still presenting start.
    assign busy   = busy_c & ~rst;
    assign result = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
//
// The stimulus process issues directed multiplies and pushes each
// hand-computed product into a queue. A monitor pops an entry on every done
// pulse and compares it with the result output. The stimulus process itself
// checks the stall length, invalid-op handling and mid-run reset.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   aluop;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_q[$];
    logic         prev_done = 1'b0;
    logic [W-1:0] last_res  = '0;

    mul_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .aluop  (aluop),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expected product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got result 0x%08h want no pulse", result);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    bad++;
                    $display("FAIL result: got 0x%08h want 0x%08h", result, e);
                end
            end
        end
        prev_done = done;
    end

    // Issue one op and follow its stall. Busy must cover the accepting cycle
    // plus WIDTH run cycles (33 in total), and done must be up once busy drops.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] expv, input bit scramble,
                          input bit hold);
        int n;
        @(posedge clk); #1;
        start = 1'b1;
        aluop = op;
        a     = va;
        b     = vb;
        exp_q.push_back(expv);
        last_res = expv;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (scramble && n == 2) begin
                a     = ~va;
                b     = va ^ vb ^ 32'h5A5A_5A5A;
                aluop = (op == 4'b0101) ? 4'b0111 : 4'b0101;
            end
            @(negedge clk);
        end
        check({name, " busy_cycles"}, W'(n), 32'd33);
        check({name, " done_after_busy"}, {31'd0, done}, 32'd1);
        if (!hold) begin
            start = 1'b0;
            aluop = 4'b0000;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        aluop = 4'b0000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("mul_7x6",        4'b0101, 32'd7,        32'd6,        32'h0000_002A, 1'b0, 1'b0);
        run_op("mulh_m1x2",      4'b0110, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("mulh_min_sq",    4'b0110, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 1'b0);
        run_op("mulhu_max_sq",   4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("mul_max_sq",     4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        run_op("mulh_3xm5",      4'b0110, 32'd3,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mulh_maxpos_sq", 4'b0110, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0, 1'b0);
        run_op("mulh_m2xm3",     4'b0110, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 1'b0, 1'b0);
        run_op("mulh_minx1",     4'b0110, 32'h8000_0000, 32'd1,       32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mulhu_minx2",    4'b0111, 32'h8000_0000, 32'd2,       32'h0000_0001, 1'b0, 1'b0);
        run_op("mul_bzero",      4'b0101, 32'h1234_5678, 32'd0,       32'h0000_0000, 1'b0, 1'b0);
        run_op("mul_m1x2",       4'b0101, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("mul_10001_sq",   4'b0101, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 1'b0);
        run_op("mulhu_10001_sq", 4'b0111, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 1'b0, 1'b0);

        // A non-multiply op with start high must never stall or complete.
        @(posedge clk); #1;
        start = 1'b1;
        aluop = 4'b0011;
        a     = 32'd1;
        b     = 32'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("invalid_op busy",   {31'd0, busy}, 32'd0);
            check("invalid_op done",   {31'd0, done}, 32'd0);
            check("invalid_op result", result, last_res);
        end
        start = 1'b0;
        aluop = 4'b0000;

        // Start stays high through DONE. A second mul follows on the next cycle.
        run_op("b2b_first",  4'b0101, 32'd7, 32'd6, 32'h0000_002A, 1'b0, 1'b1);
        run_op("b2b_second", 4'b0101, 32'd3, 32'd5, 32'h0000_000F, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN aborts the op.
        @(posedge clk); #1;
        start = 1'b1;
        aluop = 4'b0110;
        a     = 32'd100;
        b     = 32'd200;
        repeat (11) @(negedge clk);
        #2;
        rst   = 1'b1;
        start = 1'b0;
        aluop = 4'b0000;
        #1;
        check("abort busy",   {31'd0, busy}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort done",   {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort held busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = '0;

        run_op("post_reset_mul", 4'b0101, 32'd100, 32'd200, 32'h0000_4E20, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", W'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
